// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 data-memory responder.
//   - funct3 encodings of the RV32 load/store instructions
//   - responder FSM state type
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32 loads and stores (purely combinational).
// Ports:
//   funct3   in   access size/sign encoding
//   we       in   1 = store, 0 = load
//   addr_lo  in   byte offset within the word (addr[1:0])
//   wdata    in   right-aligned store data
//   rword    in   word read from RAM
//   fault    out  misaligned access or illegal funct3/we combination
//   byte_en  out  per-lane write enable
//   wword    out  store data replicated onto its lanes
//   rdata    out  load data extracted and sign/zero-extended
module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        fault,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte   = rword[{addr_lo, 3'b000} +: 8];
        rhalf   = addr_lo[1] ? rword[31:16] : rword[15:0];
        fault   = 1'b0;
        byte_en = 4'b0000;
        wword   = 32'd0;
        rdata   = 32'd0;
        case (funct3)
            F3_B: begin
                byte_en = 4'b0001 << addr_lo;
                wword   = {4{wdata[7:0]}};
                rdata   = {{24{rbyte[7]}}, rbyte};
            end
            F3_H: begin
                fault   = addr_lo[0];
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
                rdata   = {{16{rhalf[15]}}, rhalf};
            end
            F3_W: begin
                fault   = |addr_lo;
                byte_en = 4'b1111;
                wword   = wdata;
                rdata   = rword;
            end
            // Unsigned variants exist only as loads.
            F3_BU: begin
                fault = we;
                rdata = {24'd0, rbyte};
            end
            F3_HU: begin
                fault = we | addr_lo[0];
                rdata = {16'd0, rhalf};
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32IM load/store port.
// Accepts one request at a time, waits WAIT_CYCLES, performs the access on a
// word-organised RAM and returns load data / error status.
// Ports:
//   ip_clk, ip_rst        clock, asynchronous active-low reset
//   ip_req_valid/op_req_ready  request handshake
//   ip_req_we/addr/funct3/wdata  request payload
//   op_rsp_valid/ip_rsp_ready  response handshake
//   op_rsp_rdata/op_rsp_err    response payload
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        ip_clk,
    input  logic        ip_rst,
    input  logic        ip_req_valid,
    output logic        op_req_ready,
    input  logic        ip_req_we,
    input  logic [31:0] ip_req_addr,
    input  logic [2:0]  ip_req_funct3,
    input  logic [31:0] ip_req_wdata,
    output logic        op_rsp_valid,
    input  logic        ip_rsp_ready,
    output logic [31:0] op_rsp_rdata,
    output logic        op_rsp_err
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Access operands: with zero wait states the access happens on the
    // acceptance edge, so the live request is used instead of the registers.
    logic        a_we;
    logic [31:0] a_addr;
    logic [2:0]  a_f3;
    logic [31:0] a_wdata;
    logic [31:0] off;
    logic [IDX_W-1:0] idx;
    logic        in_range, fault, acc_err, go_resp, mem_we;
    logic [3:0]  byte_en;
    logic [31:0] wword, ld_data;
    logic        unused_off_bits;

    always_comb begin
        if (state_q == S_IDLE) begin
            a_we    = ip_req_we;
            a_addr  = ip_req_addr;
            a_f3    = ip_req_funct3;
            a_wdata = ip_req_wdata;
        end else begin
            a_we    = we_q;
            a_addr  = addr_q;
            a_f3    = f3_q;
            a_wdata = wdata_q;
        end
    end

    // Compare in 33 bits so a RAM ending at the top of the address map works.
    assign in_range = ({1'b0, a_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, a_addr} < END_ADDR);
    assign off      = a_addr - BASE_ADDR;
    assign idx      = off[IDX_W+1:2];
    assign unused_off_bits = ^{off[31:IDX_W+2], off[1:0]};

    mem_lane_align u_align (
        .funct3  (a_f3),
        .we      (a_we),
        .addr_lo (a_addr[1:0]),
        .wdata   (a_wdata),
        .rword   (mem_q[idx]),
        .fault   (fault),
        .byte_en (byte_en),
        .wword   (wword),
        .rdata   (ld_data)
    );

    assign acc_err = ~in_range | fault;
    assign mem_we  = go_resp & a_we & ~acc_err;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        go_resp     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ip_req_valid) begin
                    we_d    = ip_req_we;
                    addr_d  = ip_req_addr;
                    f3_d    = ip_req_funct3;
                    wdata_d = ip_req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        go_resp = 1'b1;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (ip_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (go_resp) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err | a_we) ? 32'd0 : ld_data;
        end
    end

    always_ff @(posedge ip_clk or negedge ip_rst) begin
        if (!ip_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            f3_q        <= 3'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM contents survive reset; only committed stores reach it.
    always_ff @(posedge ip_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign op_req_ready = (state_q == S_IDLE);
    assign op_rsp_valid = rsp_valid_q;
    assign op_rsp_rdata = rsp_rdata_q;
    assign op_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        ip_clk = 1'b0;
    logic        ip_rst = 1'b0;
    logic        ip_req_valid = 1'b0;
    logic        op_req_ready;
    logic        ip_req_we = 1'b0;
    logic [31:0] ip_req_addr = 32'd0;
    logic [2:0]  ip_req_funct3 = 3'd0;
    logic [31:0] ip_req_wdata = 32'd0;
    logic        op_rsp_valid;
    logic        ip_rsp_ready = 1'b1;
    logic [31:0] op_rsp_rdata;
    logic        op_rsp_err;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];   // {err, rdata}

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_2000),
        .WAIT_CYCLES (1),
        .INIT_FILE   ("")
    ) dut (
        .ip_clk        (ip_clk),
        .ip_rst        (ip_rst),
        .ip_req_valid  (ip_req_valid),
        .op_req_ready  (op_req_ready),
        .ip_req_we     (ip_req_we),
        .ip_req_addr   (ip_req_addr),
        .ip_req_funct3 (ip_req_funct3),
        .ip_req_wdata  (ip_req_wdata),
        .op_rsp_valid  (op_rsp_valid),
        .ip_rsp_ready  (ip_rsp_ready),
        .op_rsp_rdata  (op_rsp_rdata),
        .op_rsp_err    (op_rsp_err)
    );

    always #5 ip_clk = ~ip_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed on the edge following a negedge where
    // valid and ready are both high.
    always @(negedge ip_clk) begin
        if (op_rsp_valid && ip_rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_rdata", op_rsp_rdata, e[31:0]);
                chk("rsp_err", {31'd0, op_rsp_err}, {31'd0, e[32]});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the response drained.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input logic chk_lat);
        int n;
        ip_req_valid  = 1'b1;
        ip_req_we     = we;
        ip_req_addr   = addr;
        ip_req_funct3 = f3;
        ip_req_wdata  = wd;
        n = 0;
        @(negedge ip_clk);
        while (!op_req_ready && n < 100) begin
            @(negedge ip_clk);
            n++;
        end
        if (n >= 100) chk("req_accept_timeout", 32'd1, 32'd0);
        exp_q.push_back({exp_err, exp_rd});
        @(posedge ip_clk); #1;
        ip_req_valid = 1'b0;
        if (chk_lat) begin
            chk("lat_valid_edge1", {31'd0, op_rsp_valid}, 32'd0);
            @(posedge ip_clk); #1;
            chk("lat_valid_edge2", {31'd0, op_rsp_valid}, 32'd1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge ip_clk); #1;
            n++;
        end
        if (n >= 100) begin
            chk("rsp_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        @(posedge ip_clk); #1;
    endtask

    initial begin
        logic [31:0] hold_rd;
        logic        hold_err;
        int n;

        // Reset state
        #1;
        chk("rst_req_ready", {31'd0, op_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, op_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", op_rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, op_rsp_err}, 32'd0);
        repeat (2) @(posedge ip_clk);
        #1 ip_rst = 1'b1;
        @(posedge ip_clk); #1;

        // Word store/load with latency check
        do_req(1, 32'h2004, 3'd2, 32'hDEADBEEF, 32'h0, 0, 0);
        do_req(0, 32'h2004, 3'd2, 32'h0, 32'hDEADBEEF, 0, 1);

        // Byte store and byte loads
        do_req(1, 32'h2005, 3'd0, 32'h000000AA, 32'h0, 0, 0);
        do_req(0, 32'h2004, 3'd2, 32'h0, 32'hDEADAAEF, 0, 0);
        do_req(0, 32'h2005, 3'd0, 32'h0, 32'hFFFFFFAA, 0, 0);
        do_req(0, 32'h2005, 3'd4, 32'h0, 32'h000000AA, 0, 0);

        // Halfword store and loads, misaligned halfword
        do_req(1, 32'h2006, 3'd1, 32'h00008001, 32'h0, 0, 0);
        do_req(0, 32'h2006, 3'd1, 32'h0, 32'hFFFF8001, 0, 0);
        do_req(0, 32'h2006, 3'd5, 32'h0, 32'h00008001, 0, 0);
        do_req(0, 32'h2007, 3'd1, 32'h0, 32'h0, 1, 0);
        do_req(0, 32'h2004, 3'd2, 32'h0, 32'h8001AAEF, 0, 0);

        // Faulting stores must leave the word untouched
        do_req(1, 32'h2006, 3'd2, 32'h11223344, 32'h0, 1, 0);
        do_req(1, 32'h2005, 3'd1, 32'h00005555, 32'h0, 1, 0);
        do_req(1, 32'h2004, 3'd4, 32'h00000066, 32'h0, 1, 0);
        do_req(0, 32'h2004, 3'd3, 32'h0, 32'h0, 1, 0);
        do_req(0, 32'h2004, 3'd2, 32'h0, 32'h8001AAEF, 0, 0);

        // Out of range: aliasing words 1023 and 0 must be untouched
        do_req(1, 32'h2FFC, 3'd2, 32'h11111111, 32'h0, 0, 0);
        do_req(1, 32'h2000, 3'd2, 32'h22222222, 32'h0, 0, 0);
        do_req(1, 32'h1FFC, 3'd2, 32'hBADBAD00, 32'h0, 1, 0);
        do_req(0, 32'h3000, 3'd2, 32'h0, 32'h0, 1, 0);
        do_req(1, 32'h3000, 3'd2, 32'hBADBAD01, 32'h0, 1, 0);
        do_req(0, 32'h2FFC, 3'd2, 32'h0, 32'h11111111, 0, 0);
        do_req(0, 32'h2000, 3'd2, 32'h0, 32'h22222222, 0, 0);

        // Response stall with a competing request presented
        ip_rsp_ready  = 1'b0;
        ip_req_valid  = 1'b1;
        ip_req_we     = 1'b0;
        ip_req_addr   = 32'h2004;
        ip_req_funct3 = 3'd2;
        exp_q.push_back({1'b0, 32'h8001AAEF});
        @(posedge ip_clk); #1;
        ip_req_we     = 1'b1;
        ip_req_addr   = 32'h2008;
        ip_req_wdata  = 32'h5A5A5A5A;
        n = 0;
        while (!op_rsp_valid && n < 20) begin
            @(posedge ip_clk); #1;
            n++;
        end
        if (n >= 20) chk("stall_rsp_timeout", 32'd1, 32'd0);
        hold_rd  = op_rsp_rdata;
        hold_err = op_rsp_err;
        for (int i = 0; i < 5; i++) begin
            @(negedge ip_clk);
            chk("stall_valid", {31'd0, op_rsp_valid}, 32'd1);
            chk("stall_rdata", op_rsp_rdata, hold_rd);
            chk("stall_err", {31'd0, op_rsp_err}, {31'd0, hold_err});
            chk("stall_req_ready", {31'd0, op_req_ready}, 32'd0);
        end
        @(posedge ip_clk); #1;
        ip_rsp_ready = 1'b1;
        n = 0;
        @(negedge ip_clk);
        while (!op_req_ready && n < 20) begin
            @(negedge ip_clk);
            n++;
        end
        if (n >= 20) chk("stall_idle_timeout", 32'd1, 32'd0);
        chk("stall_queue_drained", exp_q.size(), 32'd0);
        exp_q.push_back({1'b0, 32'h0});
        @(posedge ip_clk); #1;
        ip_req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge ip_clk); #1;
            n++;
        end
        @(posedge ip_clk); #1;
        do_req(0, 32'h2008, 3'd2, 32'h0, 32'h5A5A5A5A, 0, 0);

        // Reset during WAIT discards the store
        do_req(1, 32'h2010, 3'd2, 32'hCAFEF00D, 32'h0, 0, 0);
        ip_req_valid  = 1'b1;
        ip_req_we     = 1'b1;
        ip_req_addr   = 32'h2010;
        ip_req_funct3 = 3'd2;
        ip_req_wdata  = 32'h12345678;
        @(negedge ip_clk);
        chk("pre_rst_ready", {31'd0, op_req_ready}, 32'd1);
        @(posedge ip_clk); #1;
        ip_req_valid = 1'b0;
        ip_rst = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, op_req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, op_rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", op_rsp_rdata, 32'd0);
        chk("midrst_rsp_err", {31'd0, op_rsp_err}, 32'd0);
        repeat (2) @(posedge ip_clk);
        #1 ip_rst = 1'b1;
        @(posedge ip_clk); #1;
        chk("postrst_rsp_valid", {31'd0, op_rsp_valid}, 32'd0);
        do_req(0, 32'h2010, 3'd2, 32'h0, 32'hCAFEF00D, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
